// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver
// Multiplexed N-digit 7-segment (FND) driver. A packed word of 4-bit digit
// codes is captured once per frame, then one digit at a time is decoded and
// its common is enabled. Each digit is held for CLK_DIV clocks.
//
// Ports:
//   i_clk     system clock
//   i_reset   synchronous, active-high reset
//   i_value   packed digit codes, nibble k = digit k (digit 0 rightmost)
//   i_dp      per-digit decimal point request, 1 = lit
//   i_blank   1 = display dark (live, not captured); scanning keeps running
//   i_lz_sup  1 = suppress leading zeros
//   o_font    segment pattern, active-low, bit7 = dp, bits6..0 = g..a
//   o_com     digit commons, one-hot at the active level (COM_ACTIVE_LOW)
module fnd_scan_driver #(
  parameter int N_DIGIT        = 4,
  parameter int CLK_DIV        = 100000,
  parameter int HEX_EN         = 1,
  parameter int COM_ACTIVE_LOW = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [4*N_DIGIT-1:0]   i_value,
  input  logic [N_DIGIT-1:0]     i_dp,
  input  logic                   i_blank,
  input  logic                   i_lz_sup,
  output logic [7:0]             o_font,
  output logic [N_DIGIT-1:0]     o_com
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(N_DIGIT);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGIT - 1);
  localparam logic [N_DIGIT-1:0] COM_OFF =
    (COM_ACTIVE_LOW != 0) ? {N_DIGIT{1'b1}} : {N_DIGIT{1'b0}};
  localparam logic [N_DIGIT-1:0] ONE_HOT_0 = {{(N_DIGIT-1){1'b0}}, 1'b1};

  logic [CW-1:0]          prescale_q, prescale_d;
  logic [IW-1:0]          digitIdx_q, digitIdx_d;
  logic [4*N_DIGIT-1:0]   snapValue_q, snapValue_d;
  logic [N_DIGIT-1:0]     snapDp_q, snapDp_d;
  logic                   snapLz_q, snapLz_d;
  logic                   firstCycle_q, firstCycle_d;
  logic [7:0]             font_q, font_d;
  logic [N_DIGIT-1:0]     com_q, com_d;

  logic                   tick;
  logic                   snapLoad;
  logic [3:0]             curCode;
  logic                   suppressed;
  logic [7:0]             glyph;

  // Code-to-glyph table, active-low, dp bit left dark (1). Without hex
  // glyphs, code A is reused as a dp-only pattern and B..F go blank.
  function automatic logic [7:0] decodeGlyph(input logic [3:0] code);
    logic [7:0] seg;
    seg = 8'hff;
    case (code)
      4'h0: seg = 8'hc0;
      4'h1: seg = 8'hf9;
      4'h2: seg = 8'ha4;
      4'h3: seg = 8'hb0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hf8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'ha: seg = (HEX_EN != 0) ? 8'h88 : 8'h7f;
      4'hb: seg = (HEX_EN != 0) ? 8'h83 : 8'hff;
      4'hc: seg = (HEX_EN != 0) ? 8'hc6 : 8'hff;
      4'hd: seg = (HEX_EN != 0) ? 8'ha1 : 8'hff;
      4'he: seg = (HEX_EN != 0) ? 8'h86 : 8'hff;
      default: seg = (HEX_EN != 0) ? 8'h8e : 8'hff;
    endcase
    return seg;
  endfunction

  // Scan timing and frame snapshot. The snapshot is refreshed right after
  // reset and at the last tick of the last digit, so a whole frame always
  // shows one coherent value.
  always_comb begin
    tick         = (prescale_q == DIV_LAST);
    prescale_d   = tick ? '0 : prescale_q + 1'b1;
    digitIdx_d   = digitIdx_q;
    if (tick) begin
      digitIdx_d = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + 1'b1;
    end
    snapLoad     = firstCycle_q | (tick & (digitIdx_q == IDX_LAST));
    snapValue_d  = snapLoad ? i_value  : snapValue_q;
    snapDp_d     = snapLoad ? i_dp     : snapDp_q;
    snapLz_d     = snapLoad ? i_lz_sup : snapLz_q;
    firstCycle_d = 1'b0;
  end

  // Glyph for the digit currently indexed. A digit is a leading zero when it
  // and every digit to its left are zero; digit 0 always shows. The dp still
  // lights on a suppressed digit.
  always_comb begin
    curCode    = snapValue_q[{digitIdx_q, 2'b00} +: 4];
    suppressed = snapLz_q && (digitIdx_q != '0) &&
                 ((snapValue_q >> {digitIdx_q, 2'b00}) == '0);
    glyph      = suppressed ? 8'hff : decodeGlyph(curCode);
    font_d     = glyph & {~snapDp_q[digitIdx_q], 7'h7f};
    com_d      = (COM_ACTIVE_LOW != 0) ? ~(ONE_HOT_0 << digitIdx_q)
                                       :  (ONE_HOT_0 << digitIdx_q);
    // The cycle right after reset still shows the idle pattern, and blank
    // darkens the next cycle without disturbing the scan position.
    if (firstCycle_q || i_blank) begin
      font_d = 8'hff;
      com_d  = COM_OFF;
    end
  end

  // State registers; outputs are registered so they trail the index by one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prescale_q   <= '0;
      digitIdx_q   <= '0;
      snapValue_q  <= '0;
      snapDp_q     <= '0;
      snapLz_q     <= 1'b0;
      firstCycle_q <= 1'b1;
      font_q       <= 8'hff;
      com_q        <= COM_OFF;
    end else begin
      prescale_q   <= prescale_d;
      digitIdx_q   <= digitIdx_d;
      snapValue_q  <= snapValue_d;
      snapDp_q     <= snapDp_d;
      snapLz_q     <= snapLz_d;
      firstCycle_q <= firstCycle_d;
      font_q       <= font_d;
      com_q        <= com_d;
    end
  end

  assign o_font = font_q;
  assign o_com  = com_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver
// Drives two fnd_scan_driver instances (hex glyphs on and off) with the same
// inputs. Expected outputs come from a model that tracks elapsed clocks since
// reset release and derives the shown digit and captured frame arithmetically.
module tb_fnd_scan_driver;

  localparam int N = 4;
  localparam int C = 4;

  typedef struct packed {
    logic [7:0] font;
    logic [3:0] com;
    logic [7:0] font0;
  } expT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        blank = 1'b0;
  logic        lz = 1'b0;
  logic [7:0]  font, font0;
  logic [3:0]  com, com0;

  fnd_scan_driver #(.N_DIGIT(N), .CLK_DIV(C), .HEX_EN(1), .COM_ACTIVE_LOW(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_value(value), .i_dp(dp),
    .i_blank(blank), .i_lz_sup(lz), .o_font(font), .o_com(com)
  );

  fnd_scan_driver #(.N_DIGIT(N), .CLK_DIV(C), .HEX_EN(0), .COM_ACTIVE_LOW(1)) dutNoHex (
    .i_clk(clk), .i_reset(reset), .i_value(value), .i_dp(dp),
    .i_blank(blank), .i_lz_sup(lz), .o_font(font0), .o_com(com0)
  );

  always #5 clk = ~clk;

  // Scoreboard and counters
  expT   expQ[$];
  string tagQ[$];
  int    total = 0;
  int    bad = 0;
  int    pushCnt = 0;
  int    popCnt = 0;

  // Reference model state: clocks since reset release and the captured frame
  int          edgeCnt = 0;
  logic [15:0] snapVal = '0;
  logic [3:0]  snapDp = '0;
  logic        snapLz = 1'b0;

  logic [7:0] digitTbl [0:9] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99,
                                 8'h92, 8'h82, 8'hf8, 8'h80, 8'h90};
  logic [7:0] hexTbl [0:5]   = '{8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};

  // Font for digit d of the captured frame, with or without hex glyphs
  function automatic logic [7:0] modelFont(input int d, input bit hex);
    logic [15:0] upper;
    int          code;
    logic [7:0]  g;
    upper = snapVal >> (4 * d);
    code  = int'(upper & 16'h000f);
    if (snapLz && d > 0 && upper == 16'h0000) g = 8'hff;
    else if (code < 10) g = digitTbl[code];
    else if (hex) g = hexTbl[code - 10];
    else g = (code == 10) ? 8'h7f : 8'hff;
    if (snapDp[d]) g[7] = 1'b0;
    return g;
  endfunction

  task automatic checkOutput(input string tag, input string what,
                             input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s/%s at %0t: got %h want %h", tag, what, $time, got, want);
    end
  endtask

  // Drive one clock worth of inputs and queue what the next edge must show
  task automatic applyStimulus(input logic rst, input logic [15:0] val,
                               input logic [3:0] dpIn, input logic blk,
                               input logic lzIn, input string tag);
    expT e;
    int  d;
    @(negedge clk);
    reset = rst;
    value = val;
    dp    = dpIn;
    blank = blk;
    lz    = lzIn;
    e.font  = 8'hff;
    e.com   = 4'hf;
    e.font0 = 8'hff;
    if (rst) begin
      edgeCnt = 0;
      snapVal = '0;
      snapDp  = '0;
      snapLz  = 1'b0;
    end else begin
      edgeCnt++;
      if (edgeCnt >= 2 && !blk) begin
        d       = ((edgeCnt - 1) / C) % N;
        e.font  = modelFont(d, 1'b1);
        e.font0 = modelFont(d, 1'b0);
        e.com   = ~(4'(1 << d));
      end
      if (edgeCnt == 1 || (edgeCnt % (N * C)) == 0) begin
        snapVal = val;
        snapDp  = dpIn;
        snapLz  = lzIn;
      end
    end
    expQ.push_back(e);
    tagQ.push_back(tag);
    pushCnt++;
  endtask

  // Monitor: compare every edge that has a queued expectation
  initial begin
    expT   e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        t = tagQ.pop_front();
        popCnt++;
        checkOutput(t, "font", font, e.font);
        checkOutput(t, "com", {4'h0, com}, {4'h0, e.com});
        checkOutput(t, "fontNoHex", font0, e.font0);
        checkOutput(t, "comNoHex", {4'h0, com0}, {4'h0, e.com});
      end
    end
  end

  initial begin
    logic [15:0] rv;
    logic [3:0]  rdp;
    logic        rlz;
    logic        rblk;
    int          hold;
    int          blkLeft;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h1234, 4'h0, 1'b0, 1'b0, "reset");
    for (int i = 0; i < 2 * N * C + 3; i++) applyStimulus(1'b0, 16'h1234, 4'h0, 1'b0, 1'b0, "scan");

    // Reset in the middle of a frame, then scan restarts at digit 0
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 16'h1234, 4'h0, 1'b0, 1'b0, "midReset");
    // Switch value while digit 1 is on display; old frame must finish
    for (int i = 1; i <= 3 * N * C; i++)
      applyStimulus(1'b0, (i < 7) ? 16'h1234 : 16'h5678, 4'h0, 1'b0, 1'b0, "coherence");

    for (int i = 0; i < 2 * N * C; i++) applyStimulus(1'b0, 16'h0050, 4'h0, 1'b0, 1'b1, "lzSup");
    for (int i = 0; i < 2 * N * C; i++) applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, "lzZero");
    for (int i = 0; i < 2 * N * C; i++) applyStimulus(1'b0, 16'h1234, 4'b0010, 1'b0, 1'b0, "dp");
    for (int i = 0; i < 2 * N * C; i++) applyStimulus(1'b0, 16'hfa3c, 4'b1000, 1'b0, 1'b0, "hex");
    for (int i = 0; i < 2 * N * C; i++) applyStimulus(1'b0, 16'h0a0f, 4'b0100, 1'b0, 1'b1, "hexLz");

    // Six-cycle blank pulse mid-scan
    for (int i = 0; i < 22; i++)
      applyStimulus(1'b0, 16'h1234, 4'h0, (i >= 7 && i < 13), 1'b0, "blank");

    // Randomized traffic with leading-zero-heavy values, blanks and rare resets
    hold = 0;
    blkLeft = 0;
    rv = 16'h0;
    rdp = 4'h0;
    rlz = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        rv   = 16'($urandom) >> (4 * $urandom_range(0, 3));
        rdp  = 4'($urandom);
        rlz  = 1'($urandom);
        hold = $urandom_range(1, 12);
      end
      hold--;
      if (blkLeft == 0 && $urandom_range(0, 29) == 0) blkLeft = $urandom_range(1, 6);
      rblk = (blkLeft > 0);
      if (blkLeft > 0) blkLeft--;
      applyStimulus($urandom_range(0, 99) == 0, rv, rdp, rblk, rlz, "random");
    end

    @(posedge clk);
    #2;
    total++;
    if (popCnt != pushCnt || expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: popped %0d want %0d", popCnt, pushCnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
